// File: rtl/edf_dispatcher_if.sv
// Request bus between the per-core queues and the EDF dispatcher.
// The master side is the dispatcher; the slave side is the queue/memory environment.
interface edf_dispatcher_if #(
   parameter int NUM_QUEUES    = 4,
   parameter int DATA_SIZE     = 8,
   parameter int REGISTER_SIZE = 32
);
   localparam int ID_WIDTH = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;

   logic [NUM_QUEUES*DATA_SIZE-1:0]     q_value;
   logic [NUM_QUEUES-1:0]               q_empty;
   logic [NUM_QUEUES-1:0]               q_consumed;
   logic [NUM_QUEUES*REGISTER_SIZE-1:0] periods;
   logic [DATA_SIZE-1:0]                out_data;
   logic [ID_WIDTH-1:0]                 out_id;
   logic                                out_valid;
   logic                                out_ready;
   logic                                busy;

   modport master (
      input  q_value, q_empty, periods, out_ready,
      output q_consumed, out_data, out_id, out_valid, busy
   );

   modport slave (
      output q_value, q_empty, periods, out_ready,
      input  q_consumed, out_data, out_id, out_valid, busy
   );
endinterface

// File: rtl/edf_dispatcher.sv
// Earliest-deadline-first dispatcher: picks the eligible queue head with the nearest
// absolute deadline, issues it on a valid/ready port and pops the source queue.
module edf_dispatcher #(
   parameter int NUM_QUEUES    = 4,
   parameter int DATA_SIZE     = 8,
   parameter int REGISTER_SIZE = 32,
   parameter int TIME_WIDTH    = 32
) (
   input logic clock,
   input logic reset,
   edf_dispatcher_if.master bus
);
   localparam int ID_WIDTH = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ISSUE  = 2'd1;
   localparam logic [1:0] GAP    = 2'd2;
   localparam logic [1:0] SETTLE = 2'd3;

   logic [1:0]            r_state;
   logic [TIME_WIDTH-1:0] r_now;
   logic [TIME_WIDTH-1:0] r_deadline [NUM_QUEUES];
   logic [NUM_QUEUES-1:0] r_stable;
   logic [NUM_QUEUES-1:0] r_consumed;
   logic [DATA_SIZE-1:0]  r_outData;
   logic [ID_WIDTH-1:0]   r_outId;
   logic                  r_outValid;

   logic [TIME_WIDTH-1:0] w_period [NUM_QUEUES];
   logic [NUM_QUEUES-1:0] w_isEdf;
   logic [NUM_QUEUES-1:0] w_eligible;
   logic                  w_anyEligible;
   logic [ID_WIDTH-1:0]   w_winner;
   logic                  w_bestEdf;
   logic [TIME_WIDTH-1:0] w_bestDeadline;
   logic [TIME_WIDTH-1:0] w_diff;

   // A zero period marks a best-effort queue; otherwise the period is fitted to the time width.
   for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_period
      logic [REGISTER_SIZE-1:0] w_raw;
      assign w_raw      = bus.periods[i*REGISTER_SIZE +: REGISTER_SIZE];
      assign w_isEdf[i] = |w_raw;
      if (TIME_WIDTH <= REGISTER_SIZE) begin : g_trunc
         assign w_period[i] = w_raw[TIME_WIDTH-1:0];
      end else begin : g_ext
         assign w_period[i] = {{(TIME_WIDTH-REGISTER_SIZE){1'b0}}, w_raw};
      end
   end

   assign w_eligible = ~bus.q_empty & r_stable;

   // Strictly-earlier replacement keeps the lowest index on ties and among best-effort queues.
   always_comb begin
      w_anyEligible  = 1'b0;
      w_winner       = '0;
      w_bestEdf      = 1'b0;
      w_bestDeadline = '0;
      w_diff         = '0;
      for (int i = 0; i < NUM_QUEUES; i++) begin
         w_diff = r_deadline[i] - w_bestDeadline;
         if (w_eligible[i]) begin
            if (!w_anyEligible || (w_isEdf[i] && (!w_bestEdf || w_diff[TIME_WIDTH-1]))) begin
               w_anyEligible  = 1'b1;
               w_winner       = ID_WIDTH'(i);
               w_bestEdf      = w_isEdf[i];
               w_bestDeadline = r_deadline[i];
            end
         end
      end
   end

   // The consumed queue is held unstable until its registered head read has caught up.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_now    <= '0;
         r_stable <= '0;
         for (int i = 0; i < NUM_QUEUES; i++) begin
            r_deadline[i] <= '0;
         end
      end else begin
         r_now    <= r_now + TIME_WIDTH'(1);
         r_stable <= ~bus.q_empty;
         if (r_state == GAP || r_state == SETTLE) begin
            r_stable[r_outId] <= 1'b0;
         end
         for (int i = 0; i < NUM_QUEUES; i++) begin
            if ((!bus.q_empty[i] && !r_stable[i]) ||
                (r_state == SETTLE && r_outId == ID_WIDTH'(i) && !bus.q_empty[i])) begin
               r_deadline[i] <= r_now + w_period[i];
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= IDLE;
         r_outData  <= '0;
         r_outId    <= '0;
         r_outValid <= 1'b0;
         r_consumed <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_anyEligible) begin
                  r_outData  <= bus.q_value[int'(w_winner)*DATA_SIZE +: DATA_SIZE];
                  r_outId    <= w_winner;
                  r_outValid <= 1'b1;
                  r_state    <= ISSUE;
               end
            end
            ISSUE: begin
               if (r_outValid && bus.out_ready) begin
                  r_outValid <= 1'b0;
                  r_consumed <= NUM_QUEUES'(1) << r_outId;
                  r_state    <= GAP;
               end
            end
            GAP: begin
               r_consumed <= '0;
               r_state    <= SETTLE;
            end
            SETTLE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.out_data   = r_outData;
   assign bus.out_id     = r_outId;
   assign bus.out_valid  = r_outValid;
   assign bus.q_consumed = r_consumed;
   assign bus.busy       = (r_state != IDLE);
endmodule

// File: tb/tb_edf_dispatcher.sv
// Directed bench for edf_dispatcher with a registered-read queue model; a second
// instance with an 8-bit time counter exercises deadline wrap-around.
module tb_edf_dispatcher;
   localparam int NQ = 4;
   localparam int DW = 8;
   localparam int RW = 32;

   logic clock = 1'b0;
   logic reset;
   int   assertions = 0;
   int   failures   = 0;

   logic [7:0] qMem [NQ][16];
   int         qRd  [NQ];
   int         qWr  [NQ];
   int         qCnt [NQ];

   always #5 clock = ~clock;

   edf_dispatcher_if #(.NUM_QUEUES(NQ), .DATA_SIZE(DW), .REGISTER_SIZE(RW)) bus ();
   edf_dispatcher_if #(.NUM_QUEUES(NQ), .DATA_SIZE(DW), .REGISTER_SIZE(RW)) wrapBus ();

   edf_dispatcher #(.NUM_QUEUES(NQ), .DATA_SIZE(DW), .REGISTER_SIZE(RW), .TIME_WIDTH(32)) dut (
      .clock(clock), .reset(reset), .bus(bus)
   );

   edf_dispatcher #(.NUM_QUEUES(NQ), .DATA_SIZE(DW), .REGISTER_SIZE(RW), .TIME_WIDTH(8)) wrapDut (
      .clock(clock), .reset(reset), .bus(wrapBus)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertions++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int q, input logic [7:0] value);
      qMem[q][qWr[q]] = value;
      qWr[q]  = (qWr[q] + 1) % 16;
      qCnt[q] = qCnt[q] + 1;
   endtask

   task automatic setPeriod(input int q, input logic [31:0] value);
      bus.periods[q*RW +: RW] = value;
   endtask

   // Queue heads are registered: a pop or push shows up one edge later.
   task automatic tick();
      logic [NQ-1:0] popNow;
      popNow = bus.q_consumed;
      @(posedge clock);
      #1;
      for (int i = 0; i < NQ; i++) begin
         bus.q_empty[i]           = (qCnt[i] == 0);
         bus.q_value[i*DW +: DW]  = qMem[i][qRd[i]];
         if (popNow[i] === 1'b1) begin
            checkOutput("popNonEmpty", 32'(qCnt[i] != 0), 32'd1);
            if (qCnt[i] != 0) begin
               qRd[i]  = (qRd[i] + 1) % 16;
               qCnt[i] = qCnt[i] - 1;
            end
         end
      end
   endtask

   task automatic waitValid(input string tag);
      int waited;
      waited = 0;
      while (bus.out_valid !== 1'b1 && waited < 30) begin
         tick();
         waited++;
      end
      checkOutput(tag, 32'(bus.out_valid), 32'd1);
   endtask

   task automatic expectDispatch(input string tag, input int id, input logic [7:0] data);
      waitValid({tag, "_valid"});
      checkOutput({tag, "_id"}, 32'(bus.out_id), 32'(id));
      checkOutput({tag, "_data"}, 32'(bus.out_data), 32'(data));
      tick();
      checkOutput({tag, "_pop"}, 32'(bus.q_consumed), 32'(1) << id);
      tick();
      checkOutput({tag, "_popEnd"}, 32'(bus.q_consumed), 32'd0);
   endtask

   task automatic idleTicks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      for (int i = 0; i < NQ; i++) begin
         qRd[i] = 0; qWr[i] = 0; qCnt[i] = 0;
         for (int j = 0; j < 16; j++) qMem[i][j] = 8'h00;
      end
      reset = 1'b1;
      bus.out_ready = 1'b0; bus.periods = '0; bus.q_empty = '1; bus.q_value = '0;
      wrapBus.out_ready = 1'b0; wrapBus.periods = '0; wrapBus.q_empty = '1; wrapBus.q_value = '0;
      tick();
      tick();
      reset = 1'b0;

      checkOutput("rstValid", 32'(bus.out_valid), 32'd0);
      checkOutput("rstConsumed", 32'(bus.q_consumed), 32'd0);
      checkOutput("rstData", 32'(bus.out_data), 32'd0);
      checkOutput("rstId", 32'(bus.out_id), 32'd0);
      checkOutput("rstBusy", 32'(bus.busy), 32'd0);

      // 240 edges after reset the 8-bit counter reads 0xF0; the first 20 also check idle quiet.
      for (int i = 0; i < 240; i++) begin
         tick();
         if (i < 20) begin
            checkOutput("emptyValid", 32'(bus.out_valid), 32'd0);
            checkOutput("emptyConsumed", 32'(bus.q_consumed), 32'd0);
            checkOutput("emptyBusy", 32'(bus.busy), 32'd0);
         end
      end
      wrapBus.periods[0*RW +: RW] = 32'h20;
      wrapBus.periods[1*RW +: RW] = 32'h08;
      wrapBus.q_value[0*DW +: DW] = 8'hA0;
      wrapBus.q_value[1*DW +: DW] = 8'hB1;
      wrapBus.q_empty = 4'b1100;
      tick();
      tick();
      checkOutput("wrapValid", 32'(wrapBus.out_valid), 32'd1);
      checkOutput("wrapId", 32'(wrapBus.out_id), 32'd1);
      checkOutput("wrapData", 32'(wrapBus.out_data), 32'hB1);

      bus.out_ready = 1'b1;
      setPeriod(2, 100);
      applyStimulus(2, 8'h5A);
      tick();
      checkOutput("q2HeadValid", 32'(bus.out_valid), 32'd0);
      tick();
      checkOutput("q2StableValid", 32'(bus.out_valid), 32'd0);
      tick();
      checkOutput("q2Valid", 32'(bus.out_valid), 32'd1);
      checkOutput("q2Data", 32'(bus.out_data), 32'h5A);
      checkOutput("q2Id", 32'(bus.out_id), 32'd2);
      checkOutput("q2NoPopYet", 32'(bus.q_consumed), 32'd0);
      tick();
      checkOutput("q2Pop", 32'(bus.q_consumed), 32'b0100);
      checkOutput("q2ValidDrop", 32'(bus.out_valid), 32'd0);
      tick();
      checkOutput("q2PopEnd", 32'(bus.q_consumed), 32'd0);
      checkOutput("q2BusySettle", 32'(bus.busy), 32'd1);
      tick();
      checkOutput("q2Idle", 32'(bus.busy), 32'd0);
      idleTicks(3);

      setPeriod(0, 50);
      setPeriod(1, 10);
      applyStimulus(0, 8'h11);
      applyStimulus(1, 8'h22);
      expectDispatch("edfShort", 1, 8'h22);
      expectDispatch("edfLong", 0, 8'h11);
      idleTicks(3);

      setPeriod(0, 30);
      setPeriod(1, 30);
      applyStimulus(0, 8'h33);
      applyStimulus(1, 8'h44);
      expectDispatch("tieLow", 0, 8'h33);
      expectDispatch("tieHigh", 1, 8'h44);
      idleTicks(3);

      setPeriod(0, 0);
      setPeriod(1, 1000);
      setPeriod(3, 0);
      applyStimulus(0, 8'h70);
      applyStimulus(3, 8'h77);
      applyStimulus(1, 8'h66);
      expectDispatch("beEdf", 1, 8'h66);
      expectDispatch("beLow", 0, 8'h70);
      expectDispatch("beHigh", 3, 8'h77);
      idleTicks(3);

      bus.out_ready = 1'b0;
      setPeriod(2, 5);
      applyStimulus(2, 8'h99);
      waitValid("bpValid");
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("bpHoldData", 32'(bus.out_data), 32'h99);
         checkOutput("bpHoldId", 32'(bus.out_id), 32'd2);
         checkOutput("bpNoPop", 32'(bus.q_consumed), 32'd0);
      end
      bus.out_ready = 1'b1;
      tick();
      checkOutput("bpPop", 32'(bus.q_consumed), 32'b0100);
      tick();
      checkOutput("bpPopEnd", 32'(bus.q_consumed), 32'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         checkOutput("bpNoRepeat", 32'(bus.out_valid), 32'd0);
      end

      setPeriod(0, 20);
      applyStimulus(0, 8'hA1);
      applyStimulus(0, 8'hB2);
      applyStimulus(0, 8'hC3);
      expectDispatch("fifoA", 0, 8'hA1);
      expectDispatch("fifoB", 0, 8'hB2);
      expectDispatch("fifoC", 0, 8'hC3);
      idleTicks(3);

      bus.out_ready = 1'b0;
      applyStimulus(1, 8'hAB);
      waitValid("rstIssueValid");
      checkOutput("rstIssueData", 32'(bus.out_data), 32'hAB);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("rstIssueValidLow", 32'(bus.out_valid), 32'd0);
      checkOutput("rstIssueConsumed", 32'(bus.q_consumed), 32'd0);
      checkOutput("rstIssueData0", 32'(bus.out_data), 32'd0);
      checkOutput("rstIssueId0", 32'(bus.out_id), 32'd0);
      checkOutput("rstIssueBusy", 32'(bus.busy), 32'd0);
      tick();
      checkOutput("rstAfterConsumed", 32'(bus.q_consumed), 32'd0);
      tick();
      checkOutput("rstAfterConsumed2", 32'(bus.q_consumed), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end
endmodule
